// File: rtl/chebyshev_pkg.sv
// chebyshev_pkg: shared Q-format defaults and requantiser width/clamp helpers.
package chebyshev_pkg;
  localparam int CHEB_WL = 24;
  localparam int CHEB_I_BITS = 8;
  localparam int CHEB_BOUNDARY = 4;
  localparam int CHEB_DROP_FRAC = 4;
  localparam int CHEB_LANES = 4;
  localparam int CHEB_CNT_W = 16;
  function automatic int requant_o(int wl, int i_bits, int boundary, int drop_frac);
    return wl - (i_bits - boundary) - drop_frac;
  endfunction
  function automatic longint max_code(int o);
    return (longint'(1) << (o - 1)) - 1;
  endfunction
  function automatic longint min_code(int o);
    return -(longint'(1) << (o - 1));
  endfunction
endpackage

// File: rtl/chebyshev_requant_lane.sv
// chebyshev_requant_lane: one lane's round (pre-register) and shift/clamp (post-register) arithmetic.
module chebyshev_requant_lane
  import chebyshev_pkg::*;
#(
  parameter int WL = CHEB_WL,
  parameter int I_BITS = CHEB_I_BITS,
  parameter int BOUNDARY = CHEB_BOUNDARY,
  parameter int DROP_FRAC = CHEB_DROP_FRAC,
  localparam int O = requant_o(WL, I_BITS, BOUNDARY, DROP_FRAC)
) (
  input  logic [WL-1:0]        x_i,
  input  logic                 round_en_i,
  output logic signed [WL:0]   r_o,
  input  logic signed [WL:0]   r_i,
  output logic [O-1:0]         y_o,
  output logic                 sat_o
);
  localparam int TW = WL + 1 - DROP_FRAC;
  localparam logic [WL:0] HALF = DROP_FRAC > 0 ? (WL + 1)'(1) << (DROP_FRAC > 0 ? DROP_FRAC - 1 : 0) : '0;
  localparam logic signed [TW-1:0] T_MAX = TW'(max_code(O));
  localparam logic signed [TW-1:0] T_MIN = TW'(min_code(O));
  logic signed [TW-1:0] t;
  // One guard bit keeps max positive plus the rounding half representable.
  assign r_o = {x_i[WL-1], x_i} + (round_en_i ? HALF : '0);
  assign t = TW'(r_i >>> DROP_FRAC);
  assign sat_o = (t > T_MAX) || (t < T_MIN);
  assign y_o = (t > T_MAX) ? O'(T_MAX) : (t < T_MIN) ? O'(T_MIN) : t[O-1:0];
endmodule

// File: rtl/chebyshev_requant_pipe.sv
// chebyshev_requant_pipe: two-stage multi-lane round/saturate requantiser with
// valid/ready flow control and a saturating clamp-event counter.
module chebyshev_requant_pipe
  import chebyshev_pkg::*;
#(
  parameter int WL = CHEB_WL,
  parameter int I_BITS = CHEB_I_BITS,
  parameter int BOUNDARY = CHEB_BOUNDARY,
  parameter int DROP_FRAC = CHEB_DROP_FRAC,
  parameter int LANES = CHEB_LANES,
  parameter int CNT_W = CHEB_CNT_W,
  localparam int K = I_BITS - BOUNDARY,
  localparam int O = WL - K - DROP_FRAC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LANES*WL-1:0]   in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  round_en,
  output logic [LANES*O-1:0]    out_data,
  output logic [LANES-1:0]      out_sat,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  sat_clr,
  output logic [CNT_W-1:0]      sat_count,
  output logic                  sat_sticky
);
  localparam int PW = $clog2(LANES + 1);
  logic [LANES-1:0][WL:0] s1_r_q, s1_r_d;
  logic s1_valid_q, out_valid_q, sat_sticky_q, sat_sticky_d, s2_load, out_hs;
  logic [LANES*O-1:0] out_data_q, out_data_d;
  logic [LANES-1:0] out_sat_q, out_sat_d;
  logic [CNT_W-1:0] sat_count_q, sat_count_d;
  logic [PW-1:0] pop;
  logic [CNT_W+PW-1:0] sum;
  assign s2_load = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s2_load;
  assign out_hs = out_valid_q && out_ready;
  assign out_data = out_data_q;
  assign out_sat = out_sat_q;
  assign out_valid = out_valid_q;
  assign sat_count = sat_count_q;
  assign sat_sticky = sat_sticky_q;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    chebyshev_requant_lane #(
      .WL(WL), .I_BITS(I_BITS), .BOUNDARY(BOUNDARY), .DROP_FRAC(DROP_FRAC)
    ) u_lane (
      .x_i(in_data[i*WL +: WL]),
      .round_en_i(round_en),
      .r_o(s1_r_d[i]),
      .r_i(s1_r_q[i]),
      .y_o(out_data_d[i*O +: O]),
      .sat_o(out_sat_d[i])
    );
  end
  // Clear wins over a same-cycle handshake, discarding that beat's events.
  always_comb begin
    pop = '0;
    for (int i = 0; i < LANES; i++) pop = pop + PW'(out_sat_q[i]);
    sum = (CNT_W + PW)'(sat_count_q) + (CNT_W + PW)'(pop);
    sat_count_d = sat_clr ? '0 : !out_hs ? sat_count_q : |sum[CNT_W+PW-1:CNT_W] ? '1 : sum[CNT_W-1:0];
    sat_sticky_d = !sat_clr && (sat_sticky_q || (out_hs && |out_sat_q));
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_r_q <= '0;
      s1_valid_q <= 1'b0;
      out_data_q <= '0;
      out_sat_q <= '0;
      out_valid_q <= 1'b0;
      sat_count_q <= '0;
      sat_sticky_q <= 1'b0;
    end else begin
      if (in_ready) s1_valid_q <= in_valid;
      if (in_ready && in_valid) s1_r_q <= s1_r_d;
      if (!out_valid_q || out_ready) out_valid_q <= s1_valid_q;
      if (s2_load) begin
        out_data_q <= out_data_d;
        out_sat_q <= out_sat_d;
      end
      sat_count_q <= sat_count_d;
      sat_sticky_q <= sat_sticky_d;
    end
  end
endmodule

// File: tb/tb_chebyshev_requant_pipe.sv
// tb_chebyshev_requant_pipe: directed and random checks of the requantiser
// against an arithmetic reference model (WL=12, I=6, B=3, D=2, 2 lanes, O=7).
module tb_chebyshev_requant_pipe;
  localparam int WL = 12;
  localparam int LN = 2;
  localparam int O = 7;
  typedef struct {
    logic [LN*O-1:0] d;
    logic [LN-1:0] s;
  } beat_t;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, round_en = 1'b0, out_ready = 1'b1, sat_clr = 1'b0;
  logic [LN*WL-1:0] in_data = '0;
  logic in_ready, out_valid, sat_sticky;
  logic [LN*O-1:0] out_data;
  logic [LN-1:0] out_sat;
  logic [1:0] sat_count;
  int n_chk = 0, fails = 0, n_out = 0, m_cnt = 0;
  logic m_sticky = 1'b0, held_v = 1'b0;
  logic [LN*O-1:0] held_d = '0;
  logic [LN-1:0] held_s = '0;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  chebyshev_requant_pipe #(
    .WL(12), .I_BITS(6), .BOUNDARY(3), .DROP_FRAC(2), .LANES(2), .CNT_W(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .round_en(round_en), .out_data(out_data), .out_sat(out_sat), .out_valid(out_valid),
    .out_ready(out_ready), .sat_clr(sat_clr), .sat_count(sat_count), .sat_sticky(sat_sticky)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Value = x / 2^DROP_FRAC (plus a half when rounding), floored, clamped to [-64, 63].
  function automatic beat_t ref_beat(input logic [LN*WL-1:0] d, input logic r);
    beat_t b;
    b.d = '0;
    b.s = '0;
    for (int i = 0; i < LN; i++) begin
      int t;
      t = (int'($signed(d[i*WL +: WL])) + (r ? 2 : 0)) >>> 2;
      b.s[i] = (t > 63) || (t < -64);
      t = (t > 63) ? 63 : (t < -64) ? -64 : t;
      b.d[i*O +: O] = 7'(t);
    end
    return b;
  endfunction

  always @(negedge clk) begin
    beat_t e;
    chk("sat_count", 32'(sat_count), 32'(m_cnt));
    chk("sat_sticky", 32'(sat_sticky), 32'(m_sticky));
    if (held_v && out_valid) begin
      chk("hold_data", 32'(out_data), 32'(held_d));
      chk("hold_sat", 32'(out_sat), 32'(held_s));
    end
    held_v = rst_n && out_valid && !out_ready;
    held_d = out_data;
    held_s = out_sat;
    if (!rst_n) begin
      exp_q.delete();
      m_cnt = 0;
      m_sticky = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) chk("unexpected_out", 32'(out_valid), 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("out_data", 32'(out_data), 32'(e.d));
          chk("out_sat", 32'(out_sat), 32'(e.s));
          if (!sat_clr) begin
            m_cnt = (m_cnt + $countones(e.s) > 3) ? 3 : m_cnt + $countones(e.s);
            m_sticky = m_sticky | (|e.s);
          end
        end
      end
      if (sat_clr) begin
        m_cnt = 0;
        m_sticky = 1'b0;
      end
      if (in_valid && in_ready) exp_q.push_back(ref_beat(in_data, round_en));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WL-1:0] a, input logic [WL-1:0] b, input logic r);
    int n = 0;
    in_data = {b, a};
    round_en = r;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, base;
    logic [LN*WL-1:0] bd[5];
    logic br[5];
    beat_t e;
    logic [WL-1:0] xa, xb;
    logic xr;
    repeat (3) step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_sat", 32'(out_sat), 32'd0);
    chk("rst_valid_after", 32'(out_valid), 32'd0);
    // basic rounding and latency
    send(12'h08E, 12'h000, 1'b0);
    chk("lat_early", 32'(out_valid), 32'd0);
    step();
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("t1_trunc", 32'(out_data), 32'({7'h00, 7'h23}));
    chk("t1_trunc_sat", 32'(out_sat), 32'd0);
    send(12'h08E, 12'h08E, 1'b1);
    step();
    chk("t1_round", 32'(out_data), 32'({7'h24, 7'h24}));
    chk("t1_round_sat", 32'(out_sat), 32'd0);
    // clamp at both ends; most-negative code is in range
    send(12'h48E, 12'hC8E, 1'b0);
    step();
    chk("t2_clamp", 32'(out_data), 32'({7'h40, 7'h3F}));
    chk("t2_clamp_sat", 32'(out_sat), 32'b11);
    step();
    chk("t2_count", 32'(sat_count), 32'd2);
    chk("t2_sticky", 32'(sat_sticky), 32'd1);
    send(12'hF00, 12'h08E, 1'b0);
    step();
    chk("t2_minneg", 32'(out_data), 32'({7'h23, 7'h40}));
    chk("t2_minneg_sat", 32'(out_sat), 32'd0);
    // rounding overflow
    send(12'h0FF, 12'h000, 1'b1);
    step();
    chk("t3_rovf", 32'(out_data), 32'({7'h00, 7'h3F}));
    chk("t3_rovf_sat", 32'(out_sat), 32'b01);
    send(12'h0FF, 12'h000, 1'b0);
    step();
    chk("t3_trunc", 32'(out_data), 32'({7'h00, 7'h3F}));
    chk("t3_trunc_sat", 32'(out_sat), 32'd0);
    step();
    // counter saturation and clear
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    chk("t5_clr_count", 32'(sat_count), 32'd0);
    chk("t5_clr_sticky", 32'(sat_sticky), 32'd0);
    for (int k = 0; k < 3; k++) begin
      send(12'h48E, 12'hC8E, 1'b0);
      step();
      step();
      chk("t5_cnt_sat", 32'(sat_count), (k == 0) ? 32'd2 : 32'd3);
    end
    send(12'h48E, 12'hC8E, 1'b0);
    step();
    chk("t5_hs_valid", 32'(out_valid), 32'd1);
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    chk("t5_clrhs_count", 32'(sat_count), 32'd0);
    chk("t5_clrhs_sticky", 32'(sat_sticky), 32'd0);
    // backpressure
    for (int i = 0; i < 5; i++) begin
      bd[i] = LN*WL'($urandom);
      br[i] = 1'($urandom_range(0, 1));
    end
    base = n_out;
    out_ready = 1'b0;
    idx = 0;
    in_data = bd[0];
    round_en = br[0];
    in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (in_ready) idx++;
      step();
      if (idx < 5) begin
        in_data = bd[idx];
        round_en = br[idx];
      end
    end
    chk("t4_accepted", 32'(idx), 32'd2);
    chk("t4_in_ready", 32'(in_ready), 32'd0);
    chk("t4_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    for (int c = 0; c < 30 && idx < 5; c++) begin
      @(negedge clk);
      if (in_ready) idx++;
      step();
      if (idx < 5) begin
        in_data = bd[idx];
        round_en = br[idx];
      end
    end
    in_valid = 1'b0;
    chk("t4_all_sent", 32'(idx), 32'd5);
    repeat (4) step();
    chk("t4_all_out", 32'(n_out - base), 32'd5);
    chk("t4_queue_empty", 32'(exp_q.size()), 32'd0);
    // reset with two beats in flight
    out_ready = 1'b0;
    send(12'($urandom), 12'($urandom), 1'b0);
    send(12'($urandom), 12'($urandom), 1'b1);
    chk("t6_inflight", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk("t6_no_valid", 32'(out_valid), 32'd0);
      step();
    end
    chk("t6_data", 32'(out_data), 32'd0);
    chk("t6_sat", 32'(out_sat), 32'd0);
    chk("t6_count", 32'(sat_count), 32'd0);
    chk("t6_sticky", 32'(sat_sticky), 32'd0);
    chk("t6_in_ready", 32'(in_ready), 32'd1);
    xa = 12'($urandom);
    xb = 12'($urandom);
    xr = 1'($urandom_range(0, 1));
    e = ref_beat({xb, xa}, xr);
    send(xa, xb, xr);
    chk("t6_lat_early", 32'(out_valid), 32'd0);
    step();
    chk("t6_lat_valid", 32'(out_valid), 32'd1);
    chk("t6_after_data", 32'(out_data), 32'(e.d));
    chk("t6_after_sat", 32'(out_sat), 32'(e.s));
    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, fails);
    $finish;
  end
endmodule
